// File: rtl/instruction_cache_pkg.sv
// ============================================================================
// instruction_cache_pkg : FSM encodings and clog2 helper for the icache
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package instruction_cache_pkg;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_FILL   = 2'd1,
        IC_REREAD = 2'd2
    } ic_state_e;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_cache_sram_1r1w.sv
// ============================================================================
// sram_1r1w : synchronous-read, one-read/one-write storage array
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sram_1r1w
    import instruction_cache_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // Only the output register is reset so the read port comes up as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/instruction_cache.sv
// ============================================================================
// instruction_cache : direct-mapped read-only icache with line refill FSM.
// Optional hit/miss statistics counters enabled by macro ICACHE_STATS_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] iaddr,
    output logic [15:0] idata,
    output logic        icache_stall,
    output logic [15:0] mem_addr,
    output logic        mem_read_en,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int OFS = clog2(LINE_WORDS);
    localparam int IDX = clog2(NUM_LINES);
    localparam int TAG = 16 - IDX - OFS;

    ic_state_e              state_q, state_d;
    logic [15:0]            lookup_addr_q, lookup_addr_d;
    logic [OFS-1:0]         cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic                   mem_read_en_q, mem_read_en_d;
    logic [15:0]            mem_addr_q, mem_addr_d;

    logic [TAG-1:0]         lk_tag;
    logic [IDX-1:0]         lk_idx;
    logic [TAG-1:0]         tag_rd;
    logic [15:0]            data_rd;
    logic [IDX+OFS-1:0]     rd_word;
    logic [OFS-1:0]         cnt_inc;
    logic                   in_idle;
    logic                   hit;
    logic                   fill_ack;
    logic                   last_word;

    assign lk_tag    = lookup_addr_q[15 -: TAG];
    assign lk_idx    = lookup_addr_q[OFS +: IDX];
    assign in_idle   = (state_q == IC_IDLE);
    assign hit       = valid_q[lk_idx] && (tag_rd == lk_tag);
    assign fill_ack  = (state_q == IC_FILL) && mem_read_en_q && mem_ack;
    assign last_word = &cnt_q;
    assign cnt_inc   = cnt_q + OFS'(1);

    // Outside IDLE the arrays re-read the pending lookup so REREAD sees the new line.
    assign rd_word   = in_idle ? iaddr[IDX+OFS-1:0] : lookup_addr_q[IDX+OFS-1:0];

    sram_1r1w #(
        .WIDTH (16),
        .DEPTH (NUM_LINES * LINE_WORDS)
    ) u_data (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_word),
        .rd_data (data_rd),
        .wr_en   (fill_ack),
        .wr_addr ({lk_idx, cnt_q}),
        .wr_data (mem_data)
    );

    sram_1r1w #(
        .WIDTH (TAG),
        .DEPTH (NUM_LINES)
    ) u_tag (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_word[OFS +: IDX]),
        .rd_data (tag_rd),
        .wr_en   (fill_ack && last_word),
        .wr_addr (lk_idx),
        .wr_data (lk_tag)
    );

    always_comb begin
        state_d       = state_q;
        lookup_addr_d = lookup_addr_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        mem_read_en_d = mem_read_en_q;
        mem_addr_d    = mem_addr_q;
        case (state_q)
            IC_IDLE: begin
                // On a miss the pending lookup is kept: the pipeline has already
                // moved iaddr on, and that next address is retried after the fill.
                if (hit) begin
                    lookup_addr_d = iaddr;
                end else begin
                    state_d       = IC_FILL;
                    cnt_d         = '0;
                    mem_read_en_d = 1'b1;
                    mem_addr_d    = {lookup_addr_q[15:OFS], {OFS{1'b0}}};
                end
            end
            IC_FILL: begin
                if (fill_ack) begin
                    cnt_d = cnt_inc;
                    if (last_word) begin
                        valid_d[lk_idx] = 1'b1;
                        mem_read_en_d   = 1'b0;
                        state_d         = IC_REREAD;
                    end else begin
                        mem_addr_d = {lookup_addr_q[15:OFS], cnt_inc};
                    end
                end
            end
            IC_REREAD: begin
                state_d = IC_IDLE;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IC_IDLE;
            lookup_addr_q <= '0;
            cnt_q         <= '0;
            valid_q       <= '0;
            mem_read_en_q <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            lookup_addr_q <= lookup_addr_d;
            cnt_q         <= cnt_d;
            valid_q       <= valid_d;
            mem_read_en_q <= mem_read_en_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    assign idata        = data_rd;
    assign icache_stall = reset || !in_idle || !hit;
    assign mem_read_en  = mem_read_en_q;
    assign mem_addr     = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (in_idle && hit && (hit_count_q != 16'hffff)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (in_idle && !hit && (miss_count_q != 16'hffff)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

`default_nettype wire
